// File: rtl/vrot_pkg.sv
// Shared widths, types and the per-lane rotate helper for the vector rotator scheduler.
package vrot_pkg;
    localparam int VEC_W   = 128;
    localparam int LANE_W  = 32;
    localparam int N_LANES = 4;
    localparam int AMT_W   = 5;

    typedef logic [VEC_W-1:0] vec_t;
    typedef logic [N_LANES-1:0][AMT_W-1:0] amt_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} vrot_state_t;

    // Doubling the lane makes the rotate a plain shift with no amount-zero special case.
    function automatic logic [LANE_W-1:0] rotl_lane(input logic [LANE_W-1:0] x,
                                                    input logic [AMT_W-1:0] a);
        logic [2*LANE_W-1:0] t;
        t = {x, x} << a;
        return t[2*LANE_W-1:LANE_W];
    endfunction
endpackage

// File: rtl/vrot32.sv
// Four-lane 32-bit rotate-left, each lane with its own 5-bit amount.
module vrot32
    import vrot_pkg::*;
(
    input  vec_t data,
    input  amt_t amt,
    output vec_t res
);
    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        assign res[k*LANE_W +: LANE_W] = rotl_lane(data[k*LANE_W +: LANE_W], amt[k]);
    end
endmodule

// File: rtl/vrot_rr_arb.sv
// Round-robin arbiter: search starts one past the last winner; pointer moves only on a grant.
module vrot_rr_arb #(
    parameter int N_REQ = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     gnt_any
);
    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0] ptr;

    always_comb begin
        int j;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (en && !gnt_any && req[j]) begin
                gnt_any = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = ID_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
endmodule

// File: rtl/vrot_sched.sv
// Shares one vrot32 between N_REQ requesters; each op loops through the rotator 1..4 times.
module vrot_sched
    import vrot_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*VEC_W-1:0]   req_data,
    input  logic [N_REQ*VEC_W-1:0]   req_rot,
    input  logic [N_REQ*2-1:0]       req_passes,
    input  logic [N_REQ*TAG_W-1:0]   req_tag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output vec_t                     rsp_data,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     busy
);
    localparam int ID_W = $clog2(N_REQ);

    vrot_state_t     state, state_nxt;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_any;

    vec_t             sel_data;
    amt_t             sel_amt;
    logic [1:0]       sel_passes;
    logic [TAG_W-1:0] sel_tag;

    vec_t             work_p0;
    amt_t             amt_p0;
    logic [TAG_W-1:0] tag_p0;
    logic [ID_W-1:0]  id_p0;
    logic [1:0]       cnt_p0;
    vec_t             rot_out;
    logic             last_pass;

    vrot_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (state == IDLE),
        .req     (req_valid),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    vrot32 u_rot (
        .data (work_p0),
        .amt  (amt_p0),
        .res  (rot_out)
    );

    assign req_ready = gnt;
    assign busy      = (state != IDLE);
    assign last_pass = (state == BUSY) && (cnt_p0 == 2'd0);

    always_comb begin
        sel_data   = '0;
        sel_amt    = '0;
        sel_passes = '0;
        sel_tag    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_data = req_data[i*VEC_W +: VEC_W];
                for (int k = 0; k < N_LANES; k++)
                    sel_amt[k] = req_rot[i*VEC_W + k*LANE_W +: AMT_W];
                sel_passes = req_passes[i*2 +: 2];
                sel_tag    = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_any) state_nxt = BUSY;
            BUSY:    if (cnt_p0 == 2'd0) state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt_p0    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_tag   <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_any)
                cnt_p0 <= sel_passes;
            else if (state == BUSY && cnt_p0 != 2'd0)
                cnt_p0 <= cnt_p0 - 2'd1;
            if (last_pass) begin
                rsp_valid <= 1'b1;
                rsp_data  <= rot_out;
                rsp_id    <= id_p0;
                rsp_tag   <= tag_p0;
            end else if (state == DONE && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Operand stage: latched on grant, then fed back through the rotator each BUSY cycle
    always_ff @(posedge clk) begin
        if (gnt_any) begin
            work_p0 <= sel_data;
            amt_p0  <= sel_amt;
            tag_p0  <= sel_tag;
            id_p0   <= gnt_idx;
        end else if (state == BUSY) begin
            work_p0 <= rot_out;
        end
    end
endmodule

// File: tb/tb_vrot_sched.sv
// Bench for vrot_sched: transaction-level reference model with per-cycle compare, plus directed literals.
module tb_vrot_sched;
    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_ready;
    logic [255:0] req_data = '0;
    logic [255:0] req_rot = '0;
    logic [3:0]   req_passes = '0;
    logic [7:0]   req_tag = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [127:0] rsp_data;
    logic [0:0]   rsp_id;
    logic [3:0]   rsp_tag;
    logic         busy;

    int checks = 0;
    int errors = 0;

    vrot_sched #(.N_REQ(N), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_rot(req_rot), .req_passes(req_passes), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Total rotation of P passes is the per-lane amount (mod 32) times P, taken mod 32.
    function automatic logic [127:0] model_rot(input logic [127:0] d, input logic [127:0] r, input int p);
        logic [127:0] o;
        logic [31:0]  x;
        int s;
        o = '0;
        for (int k = 0; k < 4; k++) begin
            x = d[k*32 +: 32];
            s = (int'(r[k*32 +: 32] % 32) * p) % 32;
            o[k*32 +: 32] = (s == 0) ? x : ((x << s) | (x >> (32 - s)));
        end
        return o;
    endfunction

    // Reference model: at most one op outstanding; response due P+1 cycles after the accept cycle.
    bit           m_active = 0;
    int           m_cnt, m_p;
    int           last_g = N - 1;
    int           g, jj;
    logic [127:0] m_data;
    logic [3:0]   m_tag;
    logic [0:0]   m_id;
    logic [1:0]   exp_ready;
    bit           exp_valid;

    always @(negedge clk) begin
        if (rst) begin
            m_active = 0;
            last_g   = N - 1;
        end else begin
            g = -1;
            if (!m_active) begin
                for (int k = 1; k <= N; k++) begin
                    jj = (last_g + k) % N;
                    if (g < 0 && req_valid[jj]) g = jj;
                end
            end
            exp_ready = (g >= 0) ? 2'(1 << g) : 2'b00;
            exp_valid = m_active && (m_cnt >= m_p + 1);
            chk("req_ready", 128'(req_ready), 128'(exp_ready));
            chk("rsp_valid", 128'(rsp_valid), 128'(exp_valid));
            chk("busy", 128'(busy), 128'(m_active));
            if (exp_valid) begin
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_id", 128'(rsp_id), 128'(m_id));
                chk("rsp_tag", 128'(rsp_tag), 128'(m_tag));
            end
            if (m_active) begin
                if (exp_valid && rsp_ready) m_active = 0;
                else m_cnt++;
            end else if (g >= 0) begin
                m_active = 1;
                m_cnt    = 1;
                m_p      = int'(req_passes[g*2 +: 2]) + 1;
                m_data   = model_rot(req_data[g*128 +: 128], req_rot[g*128 +: 128], m_p);
                m_id     = 1'(g);
                m_tag    = req_tag[g*4 +: 4];
                last_g   = g;
            end
        end
    end

    task automatic set_port(input int p, input logic [127:0] d, input logic [127:0] r,
                            input logic [1:0] ps, input logic [3:0] t);
        req_data[p*128 +: 128] = d;
        req_rot[p*128 +: 128]  = r;
        req_passes[p*2 +: 2]   = ps;
        req_tag[p*4 +: 4]      = t;
    endtask

    task automatic rand_port(input int p);
        logic [127:0] d, r;
        for (int k = 0; k < 4; k++) begin
            d[k*32 +: 32] = $urandom;
            r[k*32 +: 32] = ($urandom % 2) ? 32'($urandom % 64) : 32'($urandom);
        end
        set_port(p, d, r, 2'($urandom % 4), 4'($urandom));
    endtask

    task automatic wait_ready(input int p, output bit ok);
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL grant_timeout: port %0d never granted, required a grant", p);
        end
    endtask

    task automatic run_op(input int p, input logic [127:0] d, input logic [127:0] r,
                          input logic [1:0] ps, input logic [3:0] t, input logic [127:0] exp_d);
        bit ok;
        int n;
        set_port(p, d, r, ps, t);
        req_valid[p] = 1'b1;
        wait_ready(p, ok);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
        end
        chk("latency", 128'(n), 128'(int'(ps) + 2));
        chk("lit_data", rsp_data, exp_d);
        chk("lit_id", 128'(rsp_id), 128'(p));
        chk("lit_tag", 128'(rsp_tag), 128'(t));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        bit ok;
        int seq[$];
        logic [127:0] held;
        logic [1:0] hs;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("reset_rsp_data", rsp_data, 128'(0));
        chk("reset_rsp_id", 128'(rsp_id), 128'(0));
        chk("reset_rsp_tag", 128'(rsp_tag), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;

        run_op(0, 128'haabbccdd_eeff0011_2233bb00_aabbccdd,
               {32'd8, 32'd16, 32'd24, 32'd32}, 2'd0, 4'h3,
               128'hbbccddaa_0011eeff_002233bb_aabbccdd);
        run_op(1, {4{32'h12345678}}, {4{32'd4}}, 2'd1, 4'h9, {4{32'h34567812}});
        run_op(0, 128'h44000011_33000022_55000077_11000044,
               {32'h28, 32'h30, 32'h38, 32'h40}, 2'd0, 4'h5,
               128'h00001144_00223300_77550000_11000044);

        // Both requesters always valid: grants must alternate starting at 0.
        do_reset();
        rand_port(0);
        rand_port(1);
        req_valid = 2'b11;
        for (int c = 0; c < 200 && seq.size() < 8; c++) begin
            @(negedge clk);
            hs = req_ready;
            @(posedge clk); #1;
            if (hs != 2'b00) begin
                seq.push_back(hs[1] ? 1 : 0);
                rand_port(hs[1] ? 1 : 0);
            end
        end
        req_valid = 2'b00;
        chk("rr_count", 128'(seq.size()), 128'(8));
        foreach (seq[i]) chk("rr_order", 128'(seq[i]), 128'(i % 2));
        repeat (12) @(posedge clk);
        #1;

        // Stall the response for 5 cycles while requester 1 waits.
        rsp_ready = 1'b0;
        rand_port(0);
        req_valid[0] = 1'b1;
        wait_ready(0, ok);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rand_port(1);
        req_valid[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        held = rsp_data;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 128'(rsp_valid), 128'(1));
            chk("stall_data", rsp_data, held);
            chk("stall_ready", 128'(req_ready), 128'(0));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_hs_busy", 128'(busy), 128'(0));
        chk("post_hs_valid", 128'(rsp_valid), 128'(0));
        chk("post_hs_grant", 128'(req_ready), 128'(2'b10));
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Reset in the middle of a 4-pass op granted to requester 0.
        rand_port(0);
        req_passes[1:0] = 2'd3;
        req_valid[0] = 1'b1;
        wait_ready(0, ok);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 128'(busy), 128'(0));
        chk("rst_mid_valid", 128'(rsp_valid), 128'(0));
        @(posedge clk); #1;
        rand_port(0);
        rand_port(1);
        req_valid = 2'b11;
        @(negedge clk);
        chk("rst_mid_grant", 128'(req_ready), 128'(2'b01));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_ready(1, ok);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Random traffic with backpressure and occasional reset.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            hs = rst ? 2'b00 : req_ready;
            @(posedge clk); #1;
            rst = ($urandom % 200 == 0);
            rsp_ready = ($urandom % 4 != 0);
            for (int p = 0; p < N; p++) begin
                if (hs[p]) begin
                    req_valid[p] = 1'($urandom % 2);
                    rand_port(p);
                end else if (!req_valid[p] && ($urandom % 3 == 0)) begin
                    rand_port(p);
                    req_valid[p] = 1'b1;
                end
            end
        end
        rst = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
